apb_script_master: RTL

APB_SCRIPT_MASTER -- requirements
Module: apb_script_master

---
 rtl/POLI_types_pkg.sv | 39 +++
 rtl/apb_step_table.sv | 31 +++
 rtl/apb_script_master.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/POLI_types_pkg.sv
// Shared types and constants for the APB script master.
//   WORD_SIZE        : APB address/data width
//   *_ADDR           : peripheral register map used by scripts
//   step_op_t        : step opcodes
//   state_t          : script FSM states (also exported on dbg_state)
//   step_t           : one step-table record {op, paddr, pdata}
package POLI_types_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [WORD_SIZE-1:0] PERIPH_CTRL_ADDR   = 32'h0000_0010;
  localparam logic [WORD_SIZE-1:0] PERIPH_STATUS_ADDR = 32'h0000_0014;
  localparam logic [WORD_SIZE-1:0] PERIPH_DATA_ADDR   = 32'h0000_0018;

  typedef enum logic [2:0] {
    OP_WRITE     = 3'd0,
    OP_WRITE_RES = 3'd1,
    OP_READ      = 3'd2,
    OP_POLL      = 3'd3,
    OP_WAIT      = 3'd4,
    OP_END       = 3'd5
  } step_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_WAIT   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  typedef struct packed {
    step_op_t               op;
    logic [WORD_SIZE-1:0]   paddr;
    logic [WORD_SIZE-1:0]   pdata;
  } step_t;

endpackage

// File: rtl/apb_step_table.sv
// Step table: NUM_STEPS records, one synchronous write port, one
// combinational read port. No reset: contents survive RST.
//   clk   : clock
//   we    : write enable (already qualified by the caller)
//   waddr : write index,  wdata : record to store
//   raddr : read index,   rdata : record at raddr (combinational)
module apb_step_table
  import POLI_types_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  localparam int IDX_W    = $clog2(NUM_STEPS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  step_t            wdata,
  input  logic [IDX_W-1:0] raddr,
  output step_t            rdata
);

  step_t mem_q [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_script_master.sv
// APB script master: executes a programmable list of APB steps
// (WRITE, WRITE_RES, READ, POLL, WAIT, END) from a step table.
//   CLK, RST          : clock, synchronous active-high reset
//   start, loop_en    : run control (start ignored while busy)
//   prog_*            : step-table write port (accepted only while idle)
//   PADDR..PREADY     : APB master port
//   busy, done        : status (done is a one-cycle pulse in FINISH)
//   timeout_err       : sticky POLL timeout, cleared by a new start
//   result            : last value captured by READ/POLL
//   step_idx          : index of the current step
//   dbg_state         : current FSM state
//
// APB handshake: a transfer is SETUP (PSEL=1, PENABLE=0) for one cycle,
// then ACCESS (PSEL=1, PENABLE=1) with address/data/direction held; it
// completes on the rising edge where PSEL & PENABLE & PREADY are all 1,
// and PRDATA is sampled on that same edge.
module apb_script_master
  import POLI_types_pkg::*;
#(
  parameter int NUM_STEPS  = 16,
  parameter int POLL_LIMIT = 256,
  localparam int IDX_W     = $clog2(NUM_STEPS),
  localparam int PCNT_W    = $clog2(POLL_LIMIT + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 loop_en,
  input  logic                 prog_we,
  input  logic [IDX_W-1:0]     prog_idx,
  input  step_op_t             prog_op,
  input  logic [WORD_SIZE-1:0] prog_paddr,
  input  logic [WORD_SIZE-1:0] prog_pdata,
  output logic [WORD_SIZE-1:0] PADDR,
  output logic [WORD_SIZE-1:0] PWDATA,
  output logic                 PWRITE,
  output logic                 PSEL,
  output logic                 PENABLE,
  input  logic [WORD_SIZE-1:0] PRDATA,
  input  logic                 PREADY,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [WORD_SIZE-1:0] result,
  output logic [IDX_W-1:0]     step_idx,
  output state_t               dbg_state
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     step_idx_q, step_idx_d;
  logic [PCNT_W-1:0]    poll_cnt_q, poll_cnt_d;
  logic [WORD_SIZE-1:0] wait_cnt_q, wait_cnt_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 advance;
  logic                 apb_active;
  logic                 is_write;
  step_t                cur;

  apb_step_table #(.NUM_STEPS(NUM_STEPS)) u_table (
    .clk   (CLK),
    .we    (prog_we && !busy),
    .waddr (prog_idx),
    .wdata ('{op: prog_op, paddr: prog_paddr, pdata: prog_pdata}),
    .raddr (step_idx_q),
    .rdata (cur)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      step_idx_q    <= '0;
      poll_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_idx_q    <= step_idx_d;
      poll_cnt_q    <= poll_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_idx_d    = step_idx_q;
    poll_cnt_d    = poll_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    advance       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_FETCH;
          step_idx_d    = '0;
          timeout_err_d = 1'b0;
        end
      end
      ST_FETCH: begin
        poll_cnt_d = '0;
        case (cur.op)
          OP_WRITE, OP_WRITE_RES, OP_READ, OP_POLL: state_d = ST_SETUP;
          OP_WAIT: begin
            // A zero-length wait completes in FETCH itself.
            if (cur.pdata == '0) begin
              advance = 1'b1;
            end else begin
              wait_cnt_d = cur.pdata;
              state_d    = ST_WAIT;
            end
          end
          default: state_d = ST_FINISH;  // END and unused encodings
        endcase
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          case (cur.op)
            OP_READ: begin
              result_d = PRDATA;
              advance  = 1'b1;
            end
            OP_POLL: begin
              result_d = PRDATA;
              if ((PRDATA & cur.pdata) != '0) begin
                advance = 1'b1;
              end else if (poll_cnt_q == PCNT_W'(POLL_LIMIT - 1)) begin
                // Timeout leaves step_idx on the failing POLL.
                timeout_err_d = 1'b1;
                state_d       = ST_FINISH;
              end else begin
                poll_cnt_d = poll_cnt_q + 1'b1;
                state_d    = ST_SETUP;
              end
            end
            default: advance = 1'b1;
          endcase
        end
      end
      ST_WAIT: begin
        // wait_cnt was loaded with N, so N cycles are spent here.
        if (wait_cnt_q == WORD_SIZE'(1)) begin
          advance = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_FINISH: begin
        if (loop_en && !timeout_err_q) begin
          state_d    = ST_FETCH;
          step_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Running off the end of the table finishes the script (no wrap).
    if (advance) begin
      if (step_idx_q == IDX_W'(NUM_STEPS - 1)) begin
        state_d = ST_FINISH;
      end else begin
        step_idx_d = step_idx_q + 1'b1;
        state_d    = ST_FETCH;
      end
    end
  end

  assign apb_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign is_write   = (cur.op == OP_WRITE) || (cur.op == OP_WRITE_RES);

  assign PSEL    = apb_active;
  assign PENABLE = (state_q == ST_ACCESS);
  assign PWRITE  = apb_active && is_write;
  assign PADDR   = apb_active ? cur.paddr : '0;
  assign PWDATA  = (apb_active && is_write) ?
                   ((cur.op == OP_WRITE_RES) ? result_q : cur.pdata) : '0;

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FINISH);
  assign timeout_err = timeout_err_q;
  assign result      = result_q;
  assign step_idx    = step_idx_q;
  assign dbg_state   = state_q;

endmodule
